// File: rtl/instruction_fetch_arbiter.sv
// Shares the single-port instruction regfile between four SM fetch requesters and the
// host program-load port: one access per cycle, host first, round-robin fetches after.
module instruction_fetch_arbiter #(
  parameter int unsigned NUM_SM = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                host_write_en,
  input  logic [ADDR_W-1:0]   host_write_addr,
  input  logic [DATA_W-1:0]   host_data_in,
  output logic                host_write_ack,
  input  logic [NUM_SM-1:0]   fetch_req,
  input  logic [ADDR_W-1:0]   fetch_addr [NUM_SM],
  output logic [NUM_SM-1:0]   fetch_grant,
  output logic [NUM_SM-1:0]   fetch_valid,
  output logic [DATA_W-1:0]   fetch_data,
  output logic                rf_write_en,
  output logic [ADDR_W-1:0]   rf_write_addr,
  output logic [DATA_W-1:0]   rf_data_in,
  output logic [ADDR_W-1:0]   rf_read_addr,
  input  logic [DATA_W-1:0]   rf_data_out
);

  localparam int unsigned PTR_W    = 2;
  localparam int unsigned STREAK_W = 2;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(2);

  logic [PTR_W-1:0]    last_grant;
  logic [STREAK_W-1:0] host_streak;
  logic [PTR_W-1:0]    pend_sm;
  logic                pend_valid;
  logic [DATA_W-1:0]   data_hold;

  logic                do_write;
  logic                do_fetch;
  logic                found;
  logic [PTR_W-1:0]    sel;
  logic [PTR_W-1:0]    cand;
  logic                ret_live;

  // Arbitration: host write unless it has already starved fetches twice in a row.
  always_comb begin
    do_write = 1'b0;
    do_fetch = 1'b0;
    found    = 1'b0;
    sel      = '0;
    cand     = '0;
    if (!rst) begin
      do_write = host_write_en && ((host_streak < STREAK_MAX) || (fetch_req == '0));
      do_fetch = !do_write && (fetch_req != '0);
    end
    for (int unsigned k = 1; k <= NUM_SM; k++) begin
      cand = PTR_W'(last_grant + PTR_W'(k));
      if (!found && fetch_req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // Regfile port and handshake drive.
  always_comb begin
    host_write_ack = do_write;
    rf_write_en    = do_write;
    rf_write_addr  = do_write ? host_write_addr : '0;
    rf_data_in     = do_write ? host_data_in : '0;
    rf_read_addr   = do_fetch ? fetch_addr[sel] : '0;
    fetch_grant    = do_fetch ? (NUM_SM'(1) << sel) : '0;
  end

  // Pointer, starvation streak and read-in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= PTR_W'(3);
      host_streak <= '0;
      pend_valid  <= 1'b0;
      pend_sm     <= '0;
      data_hold   <= '0;
    end else begin
      pend_valid <= do_fetch;
      if (do_fetch) begin
        last_grant <= sel;
        pend_sm    <= sel;
      end
      if (do_fetch || (fetch_req == '0)) begin
        host_streak <= '0;
      end else if (do_write && (host_streak != STREAK_MAX)) begin
        host_streak <= host_streak + STREAK_W'(1);
      end
      if (pend_valid) begin
        data_hold <= rf_data_out;
      end
    end
  end

  // A return is dropped if reset is asserted in the cycle it would appear.
  assign ret_live    = pend_valid && !rst;
  assign fetch_valid = ret_live ? (NUM_SM'(1) << pend_sm) : '0;
  assign fetch_data  = ret_live ? rf_data_out : data_hold;

endmodule
